// File: rtl/mem_responder_if.sv
// Bus bundle between the CPU's MAR/MDR/control unit and the memory responder.
//   read / write : level request strobes from the control unit
//   address      : word address from MAR
//   data_in      : write data from MDR
//   data_out     : registered read data toward the MDR input mux
//   ready        : one-cycle completion pulse
//   busy         : responder is not idle
//   error        : one-cycle pulse, read and write were requested together
// The master modport belongs to the CPU side. The slave modport belongs to the responder.
interface mem_responder_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) ();
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              ready;
   logic              busy;
   logic              error;

   modport master (
      output read, write, address, data_in,
      input  data_out, ready, busy, error
   );

   modport slave (
      input  read, write, address, data_in,
      output data_out, ready, busy, error
   );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: a unified instruction/data RAM that sits behind MAR/MDR.
// It services Read/Write strobes with a programmable number of wait states and
// emits a one-cycle ready pulse when each access completes.
// Ports:
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset (RAM contents are kept)
//   bus    : mem_responder_if slave modport (strobes, address, data, status)
module mem_responder #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   mem_responder_if.slave  bus
);

   // The wait counter is only 4 bits wide.
   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mem_responder: WAIT_CYCLES must be in 0..15");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10,
      HOLD   = 2'b11
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              op_wr_q, op_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] dout_q;
   logic              ready_q;
   logic              error_q;
   logic              commit;

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   // Request fields are captured once in IDLE and used for the whole access,
   // so the bus may change or drop while the access is in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         op_wr_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.read ^ bus.write) begin
               op_wr_d = bus.write;
               addr_d  = bus.address;
               wdata_d = bus.data_in;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = ACCESS;
            end else if (bus.read && bus.write) begin
               // Conflicting request: no access, just wait for the strobes to drop.
               state_d = HOLD;
            end
         end
         ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               commit  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = HOLD;
         end
         HOLD: begin
            // A strobe held high must not start a second access.
            if (!(bus.read || bus.write)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered status and read data. Ready is registered from DONE, so it
   // appears one cycle after the commit, when data_out is already stable.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dout_q  <= '0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         ready_q <= (state_q == DONE);
         error_q <= (state_q == IDLE) && bus.read && bus.write;
         if (commit && !op_wr_q) begin
            dout_q <= mem_q[addr_q];
         end
      end
   end

   // RAM write port, without reset so that it maps onto block RAM. Reset
   // forces state_q to IDLE at once, which kills commit, so an interrupted
   // write never reaches the array.
   always_ff @(posedge clk_i) begin
      if (commit && op_wr_q) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   assign bus.data_out = dout_q;
   assign bus.ready    = ready_q;
   assign bus.error    = error_q;
   assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

   logic clk;
   logic rst_n [3];
   logic rd [3];
   logic wr [3];
   logic [8:0]  ad [3];
   logic [31:0] di [3];
   logic [31:0] dout [3];
   logic rdy [3];
   logic bsy [3];
   logic err [3];

   int total = 0;
   int bad = 0;

   // Index 0: WAIT_CYCLES=1, index 1: WAIT_CYCLES=3, index 2: WAIT_CYCLES=0.
   int wait_of [3] = '{1, 3, 0};

   mem_responder_if #(.ADDR_W(9), .DATA_W(32)) b0 ();
   mem_responder_if #(.ADDR_W(9), .DATA_W(32)) b1 ();
   mem_responder_if #(.ADDR_W(9), .DATA_W(32)) b2 ();

   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(1)) u_w1 (.clk_i(clk), .rst_ni(rst_n[0]), .bus(b0.slave));
   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(3)) u_w3 (.clk_i(clk), .rst_ni(rst_n[1]), .bus(b1.slave));
   mem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) u_w0 (.clk_i(clk), .rst_ni(rst_n[2]), .bus(b2.slave));

   assign b0.read = rd[0];  assign b0.write = wr[0];  assign b0.address = ad[0];  assign b0.data_in = di[0];
   assign b1.read = rd[1];  assign b1.write = wr[1];  assign b1.address = ad[1];  assign b1.data_in = di[1];
   assign b2.read = rd[2];  assign b2.write = wr[2];  assign b2.address = ad[2];  assign b2.data_in = di[2];
   assign dout[0] = b0.data_out; assign rdy[0] = b0.ready; assign bsy[0] = b0.busy; assign err[0] = b0.error;
   assign dout[1] = b1.data_out; assign rdy[1] = b1.ready; assign bsy[1] = b1.busy; assign err[1] = b1.error;
   assign dout[2] = b2.data_out; assign rdy[2] = b2.ready; assign bsy[2] = b2.busy; assign err[2] = b2.error;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete access on responder d: drive at a negedge, count edges until
   // Ready is seen, check the latency, then drop the strobe for one edge.
   task automatic access(input int d, input bit w, input logic [8:0] a,
                         input logic [31:0] dat, input string tag);
      int n;
      rd[d] = !w; wr[d] = w; ad[d] = a; di[d] = dat;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy[d] && n < 40);
      chk({tag, "_latency"}, 32'(n - 1), 32'(wait_of[d] + 2));
      $display("txn %s: dut=%0d %s addr=%h data=%h dout=%h edges=%0d",
               tag, d, w ? "WR" : "RD", a, dat, dout[d], n - 1);
      rd[d] = 1'b0; wr[d] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int pulses;
      int errs;
      for (int i = 0; i < 3; i++) begin
         rst_n[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; di[i] = '0;
      end
      repeat (2) @(negedge clk);
      chk("rst_dout", dout[0], 32'h0);
      chk("rst_ready", 32'(rdy[0]), 32'h0);
      chk("rst_busy", 32'(bsy[0]), 32'h0);
      chk("rst_error", 32'(err[0]), 32'h0);
      for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
      @(negedge clk);

      // Preload through the bus.
      access(0, 1'b1, 9'h005, 32'hDEADBEEF, "pre_wr005");
      access(0, 1'b1, 9'h000, 32'h11111111, "pre_wr000");

      // T1: read with one wait state, cycle by cycle.
      rd[0] = 1'b1; ad[0] = 9'h005;
      @(negedge clk);                                  // after E0
      chk("t1_busy_e0", 32'(bsy[0]), 32'h1);
      chk("t1_ready_e0", 32'(rdy[0]), 32'h0);
      ad[0] = 9'h1AB;                                  // address change must not matter
      @(negedge clk);                                  // after E1
      chk("t1_ready_e1", 32'(rdy[0]), 32'h0);
      @(negedge clk);                                  // after E2
      chk("t1_dout_e2", dout[0], 32'hDEADBEEF);
      chk("t1_ready_e2", 32'(rdy[0]), 32'h0);
      @(negedge clk);                                  // after E3
      chk("t1_ready_e3", 32'(rdy[0]), 32'h1);
      chk("t1_error", 32'(err[0]), 32'h0);
      $display("txn t1_rd005: dout=%h", dout[0]);
      rd[0] = 1'b0;
      @(negedge clk);
      chk("t1_ready_off", 32'(rdy[0]), 32'h0);
      chk("t1_busy_off", 32'(bsy[0]), 32'h0);

      // T2: write top address, read it back, and check address 0 is untouched.
      access(0, 1'b1, 9'h1FF, 32'h12345678, "t2_wr1ff");
      access(0, 1'b0, 9'h1FF, 32'h0, "t2_rd1ff");
      chk("t2_dout_1ff", dout[0], 32'h12345678);
      access(0, 1'b0, 9'h000, 32'h0, "t2_rd000");
      chk("t2_dout_000", dout[0], 32'h11111111);

      // T3: read held for 8 cycles gives exactly one Ready.
      rd[0] = 1'b1; ad[0] = 9'h1FF;
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (rdy[0]) pulses++;
      end
      chk("t3_pulses", 32'(pulses), 32'h1);
      chk("t3_busy_held", 32'(bsy[0]), 32'h1);
      rd[0] = 1'b0;
      @(negedge clk);
      chk("t3_busy_released", 32'(bsy[0]), 32'h0);
      $display("txn t3_held_read: pulses=%0d", pulses);

      // T4: simultaneous read and write.
      rd[0] = 1'b1; wr[0] = 1'b1; ad[0] = 9'h005; di[0] = 32'h0BADF00D;
      @(negedge clk);
      chk("t4_error_pulse", 32'(err[0]), 32'h1);
      chk("t4_busy", 32'(bsy[0]), 32'h1);
      pulses = 0; errs = 0;
      repeat (4) begin
         @(negedge clk);
         if (rdy[0]) pulses++;
         if (err[0]) errs++;
      end
      chk("t4_no_ready", 32'(pulses), 32'h0);
      chk("t4_error_once", 32'(errs), 32'h0);
      rd[0] = 1'b0; wr[0] = 1'b0;
      @(negedge clk);
      chk("t4_idle", 32'(bsy[0]), 32'h0);
      $display("txn t4_conflict: extra_ready=%0d extra_error=%0d", pulses, errs);
      access(0, 1'b0, 9'h005, 32'h0, "t4_rd005");
      chk("t4_mem_kept", dout[0], 32'hDEADBEEF);

      // T5: reset in the middle of a write with three wait states.
      access(1, 1'b1, 9'h010, 32'h00000000, "t5_clear010");
      access(1, 1'b1, 9'h011, 32'h77777777, "t5_wr011");
      access(1, 1'b0, 9'h011, 32'h0, "t5_rd011");
      chk("t5_dout_pre", dout[1], 32'h77777777);
      wr[1] = 1'b1; ad[1] = 9'h010; di[1] = 32'hCAFEF00D;
      @(negedge clk);                                  // after E0, counter=3
      @(negedge clk);                                  // after E1, counter=2
      chk("t5_busy_pre", 32'(bsy[1]), 32'h1);
      wr[1] = 1'b0;
      #2 rst_n[1] = 1'b0;
      #1;
      chk("t5_rst_dout", dout[1], 32'h0);
      chk("t5_rst_busy", 32'(bsy[1]), 32'h0);
      chk("t5_rst_ready", 32'(rdy[1]), 32'h0);
      chk("t5_rst_error", 32'(err[1]), 32'h0);
      repeat (4) @(negedge clk);
      rst_n[1] = 1'b1;
      @(negedge clk);
      $display("txn t5_reset_during_write");
      access(1, 1'b0, 9'h010, 32'h0, "t5_rd010");
      chk("t5_mem_unchanged", dout[1], 32'h0);

      // T6: zero wait states.
      access(2, 1'b1, 9'h020, 32'hA5A5A5A5, "t6_wr020");
      access(2, 1'b0, 9'h020, 32'h0, "t6_rd020");
      chk("t6_dout", dout[2], 32'hA5A5A5A5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
